sort_array: RTL and testbench

SORT_ARRAY -- requirements
Module: sort_array

---
 rtl/sort_array_pkg.sv | 17 +
 rtl/sort_array_if.sv | 34 +++
 rtl/sort_array_cell.sv | 85 ++++++++
 rtl/sort_array.sv | 160 ++++++++++++++++
 tb/tb_sort_array.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sort_array_pkg.sv
// Shared definitions for the sorted insert array: FSM state encoding and
// the width of the priority field extracted from each entry.
// Imported by the interface-facing top and by every storage cell.
package sort_pkg;

  // Control FSM encoding (plain constants so older tools can read them too).
  localparam int ST_W = 2;
  localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
  localparam logic [ST_W-1:0] ST_CMP   = 2'd1;
  localparam logic [ST_W-1:0] ST_SHIFT = 2'd2;

  // Number of bits in the priority field [hi-1:lo].
  function automatic int pri_width(input int lo, input int hi);
    return hi - lo;
  endfunction

endpackage

// File: rtl/sort_array_if.sv
// Insert / head / evict bundle of the sorted array.
// master: producer+consumer side (drives in_data/in_valid/pop).
// slave : the array itself (drives ready, head, status and evict outputs).
interface sort_array_if #(
  parameter int SORT_WIDTH = 32,
  parameter int DEPTH      = 8
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [SORT_WIDTH-1:0] in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic [SORT_WIDTH-1:0] top_data;
  logic                  top_valid;
  logic                  pop;
  logic [CNT_W-1:0]      count;
  logic                  full;
  logic                  empty;
  logic [SORT_WIDTH-1:0] evict_data;
  logic                  evict_valid;

  modport master (
    output in_data, in_valid, pop,
    input  in_ready, top_data, top_valid, count, full, empty,
           evict_data, evict_valid
  );

  modport slave (
    input  in_data, in_valid, pop,
    output in_ready, top_data, top_valid, count, full, empty,
           evict_data, evict_valid
  );

endinterface

// File: rtl/sort_array_cell.sv
// One slot of the sorted array: entry storage, valid bit, "new goes before me" flag.
// Latency: flag registered on cmp_en edge; contents move on shift_en/pop_en edge.
// Backpressure: none locally; the top FSM sequences cmp/shift/pop one at a time.
// Ports: stage_dat is the staged entry; prev_* / next_* are the neighbour cells
// toward head / tail; prev_keep says the head-side neighbour stays put on shift.
module sort_array_cell
  import sort_pkg::*;
#(
  parameter int SORT_WIDTH    = 32,
  parameter int PRI_POS_START = 0,
  parameter int PRI_POS_END   = 32,
  parameter int DESCENDING    = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmp_en,
  input  logic                  shift_en,
  input  logic                  pop_en,
  input  logic [SORT_WIDTH-1:0] stage_dat,
  input  logic                  prev_keep,
  input  logic [SORT_WIDTH-1:0] prev_dat,
  input  logic                  prev_vld,
  input  logic [SORT_WIDTH-1:0] next_dat,
  input  logic                  next_vld,
  output logic [SORT_WIDTH-1:0] dat_q,
  output logic                  vld_q,
  output logic                  keep
);

  localparam int PRI_W = pri_width(PRI_POS_START, PRI_POS_END);

  logic [SORT_WIDTH-1:0] dat_d;
  logic                  vld_d;
  logic                  flag_q, flag_d;
  logic [PRI_W-1:0]      my_pri, stage_pri;
  logic                  new_first;

  assign my_pri    = dat_q[PRI_POS_END-1:PRI_POS_START];
  assign stage_pri = stage_dat[PRI_POS_END-1:PRI_POS_START];

  // Strict compare: an equal priority does not jump ahead, so equals keep
  // arrival order.
  assign new_first = (DESCENDING != 0) ? (stage_pri > my_pri)
                                       : (stage_pri < my_pri);

  // Occupied and ahead of the new entry: this cell holds still on shift.
  // Flags form a suffix over the valid region, so keep bits form a prefix.
  assign keep = vld_q && !flag_q;

  always_comb begin
    dat_d  = dat_q;
    vld_d  = vld_q;
    flag_d = flag_q;
    if (cmp_en) begin
      flag_d = vld_q && new_first;
    end
    if (shift_en && !keep) begin
      if (prev_keep) begin
        // First cell not kept: the staged entry lands here.
        dat_d = stage_dat;
        vld_d = 1'b1;
      end else begin
        dat_d = prev_dat;
        vld_d = prev_vld;
      end
    end
    if (pop_en) begin
      dat_d = next_dat;
      vld_d = next_vld;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dat_q  <= '0;
      vld_q  <= 1'b0;
      flag_q <= 1'b0;
    end else begin
      dat_q  <= dat_d;
      vld_q  <= vld_d;
      flag_q <= flag_d;
    end
  end

endmodule

// File: rtl/sort_array.sv
// Sorted insert array (priority queue): head = best priority, ties in arrival order.
// Latency: insert visible after the SHIFT edge (accept, CMP, SHIFT); pop takes effect on its edge.
// Backpressure: in_ready low while busy, while a pop is taken, or when full unless DROP_ON_FULL.
// Ports: clk, reset_n (async active-low), bus = sort_array_if.slave carrying
// insert handshake, head/pop, count/full/empty and the evict pulse.
module sort_array
  import sort_pkg::*;
#(
  parameter int SORT_WIDTH    = 32,
  parameter int DEPTH         = 8,
  parameter int PRI_POS_START = 0,
  parameter int PRI_POS_END   = 32,
  parameter int DESCENDING    = 0,
  parameter int DROP_ON_FULL  = 0
) (
  input  logic          clk,
  input  logic          reset_n,
  sort_array_if.slave   bus
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

  logic [ST_W-1:0]       state_q, state_d;
  logic [SORT_WIDTH-1:0] stage_q, stage_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [SORT_WIDTH-1:0] evict_dat_q, evict_dat_d;
  logic                  evict_vld_q, evict_vld_d;

  logic [SORT_WIDTH-1:0] cell_dat [DEPTH];
  logic [DEPTH-1:0]      cell_vld;
  logic [DEPTH-1:0]      cell_keep;

  logic cmp_en, shift_en, pop_en;
  logic full, empty, top_vld, in_rdy, fire_pop, fire_in;

  assign full     = (count_q == CNT_FULL);
  assign empty    = (count_q == '0);
  assign top_vld  = (state_q == ST_IDLE) && !empty;
  assign fire_pop = bus.pop && top_vld;
  // A taken pop owns the cycle; the insert waits for the next one.
  assign in_rdy   = (state_q == ST_IDLE) && !fire_pop
                    && (!full || (DROP_ON_FULL != 0));
  assign fire_in  = bus.in_valid && in_rdy;

  always_comb begin
    state_d     = state_q;
    stage_d     = stage_q;
    count_d     = count_q;
    evict_dat_d = evict_dat_q;
    evict_vld_d = 1'b0;
    cmp_en      = 1'b0;
    shift_en    = 1'b0;
    pop_en      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (fire_pop) begin
          pop_en  = 1'b1;
          count_d = count_q - CNT_ONE;
        end else if (fire_in) begin
          stage_d = bus.in_data;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        cmp_en  = 1'b1;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        shift_en = 1'b1;
        state_d  = ST_IDLE;
        if (cell_vld[DEPTH-1]) begin
          // Tail occupied: something falls off. If every cell is kept the
          // staged entry sorts last and is itself the casualty.
          evict_vld_d = 1'b1;
          evict_dat_d = cell_keep[DEPTH-1] ? stage_q : cell_dat[DEPTH-1];
        end else begin
          count_d = count_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      stage_q     <= '0;
      count_q     <= '0;
      evict_dat_q <= '0;
      evict_vld_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      stage_q     <= stage_d;
      count_q     <= count_d;
      evict_dat_q <= evict_dat_d;
      evict_vld_q <= evict_vld_d;
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    logic [SORT_WIDTH-1:0] prev_dat, next_dat;
    logic                  prev_vld, next_vld, prev_keep;

    if (i == 0) begin : g_head
      // Nothing sits ahead of the head, so it takes the staged entry
      // whenever it is not itself kept.
      assign prev_dat  = '0;
      assign prev_vld  = 1'b0;
      assign prev_keep = 1'b1;
    end else begin : g_body
      assign prev_dat  = cell_dat[i-1];
      assign prev_vld  = cell_vld[i-1];
      assign prev_keep = cell_keep[i-1];
    end

    if (i == DEPTH - 1) begin : g_tail
      assign next_dat = '0;
      assign next_vld = 1'b0;
    end else begin : g_mid
      assign next_dat = cell_dat[i+1];
      assign next_vld = cell_vld[i+1];
    end

    sort_array_cell #(
      .SORT_WIDTH    (SORT_WIDTH),
      .PRI_POS_START (PRI_POS_START),
      .PRI_POS_END   (PRI_POS_END),
      .DESCENDING    (DESCENDING)
    ) u_cell (
      .clk       (clk),
      .reset_n   (reset_n),
      .cmp_en    (cmp_en),
      .shift_en  (shift_en),
      .pop_en    (pop_en),
      .stage_dat (stage_q),
      .prev_keep (prev_keep),
      .prev_dat  (prev_dat),
      .prev_vld  (prev_vld),
      .next_dat  (next_dat),
      .next_vld  (next_vld),
      .dat_q     (cell_dat[i]),
      .vld_q     (cell_vld[i]),
      .keep      (cell_keep[i])
    );
  end

  assign bus.in_ready    = in_rdy;
  assign bus.top_data    = cell_dat[0];
  assign bus.top_valid   = top_vld;
  assign bus.count       = count_q;
  assign bus.full        = full;
  assign bus.empty       = empty;
  assign bus.evict_data  = evict_dat_q;
  assign bus.evict_valid = evict_vld_q;

endmodule

// File: tb/tb_sort_array.sv
// Directed bench for sort_array: four instances (ascending/8, descending/8,
// depth 4 reject-on-full, depth 4 evict-on-full) share stimulus; sel picks
// which one sees in_valid/pop and whose outputs are observed.
// Entries are 16 bits: priority in [15:8], payload tag in [7:0].
module tb_sort_array;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  sel;
  logic [15:0] in_data;
  logic        in_valid;
  logic        pop;

  logic        o_rdy, o_tv, o_full, o_empty, o_evv;
  logic [15:0] o_top, o_evd;
  logic [3:0]  o_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sort_array_if #(.SORT_WIDTH(16), .DEPTH(8)) if0 ();
  sort_array_if #(.SORT_WIDTH(16), .DEPTH(8)) if1 ();
  sort_array_if #(.SORT_WIDTH(16), .DEPTH(4)) if2 ();
  sort_array_if #(.SORT_WIDTH(16), .DEPTH(4)) if3 ();

  assign if0.in_data  = in_data;
  assign if1.in_data  = in_data;
  assign if2.in_data  = in_data;
  assign if3.in_data  = in_data;
  assign if0.in_valid = in_valid && (sel == 2'd0);
  assign if1.in_valid = in_valid && (sel == 2'd1);
  assign if2.in_valid = in_valid && (sel == 2'd2);
  assign if3.in_valid = in_valid && (sel == 2'd3);
  assign if0.pop      = pop && (sel == 2'd0);
  assign if1.pop      = pop && (sel == 2'd1);
  assign if2.pop      = pop && (sel == 2'd2);
  assign if3.pop      = pop && (sel == 2'd3);

  sort_array #(.SORT_WIDTH(16), .DEPTH(8), .PRI_POS_START(8), .PRI_POS_END(16),
               .DESCENDING(0), .DROP_ON_FULL(0))
    u_asc (.clk(clk), .reset_n(reset_n), .bus(if0.slave));
  sort_array #(.SORT_WIDTH(16), .DEPTH(8), .PRI_POS_START(8), .PRI_POS_END(16),
               .DESCENDING(1), .DROP_ON_FULL(0))
    u_desc (.clk(clk), .reset_n(reset_n), .bus(if1.slave));
  sort_array #(.SORT_WIDTH(16), .DEPTH(4), .PRI_POS_START(8), .PRI_POS_END(16),
               .DESCENDING(0), .DROP_ON_FULL(0))
    u_rej (.clk(clk), .reset_n(reset_n), .bus(if2.slave));
  sort_array #(.SORT_WIDTH(16), .DEPTH(4), .PRI_POS_START(8), .PRI_POS_END(16),
               .DESCENDING(0), .DROP_ON_FULL(1))
    u_drop (.clk(clk), .reset_n(reset_n), .bus(if3.slave));

  always_comb begin
    case (sel)
      2'd0: begin
        o_rdy = if0.in_ready; o_top = if0.top_data; o_tv = if0.top_valid;
        o_cnt = if0.count; o_full = if0.full; o_empty = if0.empty;
        o_evd = if0.evict_data; o_evv = if0.evict_valid;
      end
      2'd1: begin
        o_rdy = if1.in_ready; o_top = if1.top_data; o_tv = if1.top_valid;
        o_cnt = if1.count; o_full = if1.full; o_empty = if1.empty;
        o_evd = if1.evict_data; o_evv = if1.evict_valid;
      end
      2'd2: begin
        o_rdy = if2.in_ready; o_top = if2.top_data; o_tv = if2.top_valid;
        o_cnt = {1'b0, if2.count}; o_full = if2.full; o_empty = if2.empty;
        o_evd = if2.evict_data; o_evv = if2.evict_valid;
      end
      default: begin
        o_rdy = if3.in_ready; o_top = if3.top_data; o_tv = if3.top_valid;
        o_cnt = {1'b0, if3.count}; o_full = if3.full; o_empty = if3.empty;
        o_evd = if3.evict_data; o_evv = if3.evict_valid;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Offer one entry, wait (bounded) for acceptance, then let CMP and SHIFT
  // complete. Returns #1 after the SHIFT edge.
  task automatic insert(input logic [15:0] d);
    int n;
    n = 0;
    in_data  = d;
    in_valid = 1'b1;
    #1;
    while (!o_rdy && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!o_rdy) begin
      chk("insert_ready_timeout", {31'd0, o_rdy}, 32'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
    end
  endtask

  task automatic pop_expect(input string tag, input logic [15:0] exp);
    chk({tag, "_valid"}, {31'd0, o_tv}, 32'd1);
    chk({tag, "_data"}, {16'd0, o_top}, {16'd0, exp});
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    reset_n  = 1'b0;
    sel      = 2'd0;
    in_data  = '0;
    in_valid = 1'b0;
    pop      = 1'b0;
    #12;
    chk("rst_in_ready",  {31'd0, o_rdy},   32'd1);
    chk("rst_top_valid", {31'd0, o_tv},    32'd0);
    chk("rst_empty",     {31'd0, o_empty}, 32'd1);
    chk("rst_full",      {31'd0, o_full},  32'd0);
    chk("rst_top_data",  {16'd0, o_top},   32'd0);
    chk("rst_count",     {28'd0, o_cnt},   32'd0);
    chk("rst_evict_vld", {31'd0, o_evv},   32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;

    // Ascending with a tie: 5a, 2b, 9c, 2d -> b d a c. First insert timed.
    sel = 2'd0;
    in_data = 16'h050A; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("lat_cmp_tv",   {31'd0, o_tv},  32'd0);
    chk("lat_cmp_cnt",  {28'd0, o_cnt}, 32'd0);
    @(posedge clk); #1;
    chk("lat_shift_tv", {31'd0, o_tv},  32'd0);
    @(posedge clk); #1;
    chk("lat_done_tv",  {31'd0, o_tv},  32'd1);
    chk("lat_done_cnt", {28'd0, o_cnt}, 32'd1);
    chk("lat_done_top", {16'd0, o_top}, 32'h050A);
    insert(16'h020B);
    insert(16'h090C);
    insert(16'h020D);
    chk("asc_cnt4", {28'd0, o_cnt}, 32'd4);
    pop_expect("asc_pop0", 16'h020B);
    chk("asc_cnt3", {28'd0, o_cnt}, 32'd3);
    pop_expect("asc_pop1", 16'h020D);
    chk("asc_cnt2", {28'd0, o_cnt}, 32'd2);
    pop_expect("asc_pop2", 16'h050A);
    chk("asc_cnt1", {28'd0, o_cnt}, 32'd1);
    pop_expect("asc_pop3", 16'h090C);
    chk("asc_cnt0",  {28'd0, o_cnt},   32'd0);
    chk("asc_empty", {31'd0, o_empty}, 32'd1);

    // Descending: 1, 7, 3 -> head 7 right after the last insert's SHIFT.
    sel = 2'd1;
    insert(16'h0101);
    insert(16'h0702);
    insert(16'h0303);
    chk("desc_top", {16'd0, o_top}, 32'h0702);
    pop_expect("desc_pop0", 16'h0702);
    pop_expect("desc_pop1", 16'h0303);
    pop_expect("desc_pop2", 16'h0101);
    chk("desc_empty", {31'd0, o_empty}, 32'd1);

    // Depth 4, reject when full.
    sel = 2'd2;
    insert(16'h0A00);
    insert(16'h1400);
    insert(16'h1E00);
    insert(16'h2800);
    chk("rej_full", {31'd0, o_full}, 32'd1);
    chk("rej_rdy",  {31'd0, o_rdy},  32'd0);
    in_data = 16'h0500; in_valid = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rej_hold_cnt", {28'd0, o_cnt}, 32'd4);
    chk("rej_hold_top", {16'd0, o_top}, 32'h0A00);
    chk("rej_hold_rdy", {31'd0, o_rdy}, 32'd0);
    chk("rej_hold_ev",  {31'd0, o_evv}, 32'd0);
    in_valid = 1'b0;

    // Depth 4, evict when full.
    sel = 2'd3;
    insert(16'h0A00);
    insert(16'h1400);
    insert(16'h1E00);
    insert(16'h2800);
    chk("drop_full", {31'd0, o_full}, 32'd1);
    chk("drop_rdy",  {31'd0, o_rdy},  32'd1);
    insert(16'h0F00);
    chk("drop15_evv", {31'd0, o_evv}, 32'd1);
    chk("drop15_evd", {16'd0, o_evd}, 32'h2800);
    chk("drop15_cnt", {28'd0, o_cnt}, 32'd4);
    @(posedge clk); #1;
    chk("drop15_pulse_end", {31'd0, o_evv}, 32'd0);
    insert(16'h3200);
    chk("drop50_evv", {31'd0, o_evv}, 32'd1);
    chk("drop50_evd", {16'd0, o_evd}, 32'h3200);
    chk("drop50_cnt", {28'd0, o_cnt}, 32'd4);
    pop_expect("drop_pop0", 16'h0A00);
    chk("drop_pulse_gone", {31'd0, o_evv}, 32'd0);
    pop_expect("drop_pop1", 16'h0F00);
    pop_expect("drop_pop2", 16'h1400);
    pop_expect("drop_pop3", 16'h1E00);
    chk("drop_empty", {31'd0, o_empty}, 32'd1);

    // Pop and insert in the same idle cycle: pop wins, insert next cycle.
    sel = 2'd0;
    insert(16'h0300);
    insert(16'h0100);
    insert(16'h0200);
    chk("pi_cnt3", {28'd0, o_cnt}, 32'd3);
    in_data = 16'h0000; in_valid = 1'b1; pop = 1'b1;
    #1;
    chk("pi_rdy_low", {31'd0, o_rdy}, 32'd0);
    chk("pi_top",     {16'd0, o_top}, 32'h0100);
    @(posedge clk); #1;
    pop = 1'b0;
    #1;
    chk("pi_cnt2",     {28'd0, o_cnt}, 32'd2);
    chk("pi_top_next", {16'd0, o_top}, 32'h0200);
    chk("pi_rdy_high", {31'd0, o_rdy}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("pi_ins_cnt", {28'd0, o_cnt}, 32'd3);
    chk("pi_ins_top", {16'd0, o_top}, 32'h0000);
    pop_expect("pi_pop0", 16'h0000);
    pop_expect("pi_pop1", 16'h0200);
    pop_expect("pi_pop2", 16'h0300);
    pop = 1'b1;
    @(posedge clk); #1;
    pop = 1'b0;
    chk("pop_empty_cnt",   {28'd0, o_cnt},   32'd0);
    chk("pop_empty_empty", {31'd0, o_empty}, 32'd1);
    chk("pop_empty_tv",    {31'd0, o_tv},    32'd0);

    // Reset during CMP of an insert into two entries.
    insert(16'h0400);
    insert(16'h0600);
    chk("mid_cnt2", {28'd0, o_cnt}, 32'd2);
    in_data = 16'h0500; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_cnt",   {28'd0, o_cnt},   32'd0);
    chk("mid_rst_tv",    {31'd0, o_tv},    32'd0);
    chk("mid_rst_empty", {31'd0, o_empty}, 32'd1);
    chk("mid_rst_rdy",   {31'd0, o_rdy},   32'd1);
    chk("mid_rst_top",   {16'd0, o_top},   32'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_cnt", {28'd0, o_cnt}, 32'd0);
    chk("post_rst_tv",  {31'd0, o_tv},  32'd0);
    insert(16'h0700);
    chk("post_ins_cnt", {28'd0, o_cnt}, 32'd1);
    chk("post_ins_tv",  {31'd0, o_tv},  32'd1);
    chk("post_ins_top", {16'd0, o_top}, 32'h0700);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
